mem_port_arbiter: RTL

//  Sequences the single-port instruction/data memory between instruction fetch (P1) and

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-port instruction/data memory between instruction fetch and
// load/store access. Grants one port at a time from IDLE with alternating
// priority, waits RD_LAT cycles for read data or spends one cycle on a write,
// and returns a registered one-cycle valid/done pulse to the owning port.
//
// Parameters
//   ADDR_W  memory address width
//   DATA_W  memory word width
//   RD_LAT  grant edge to m_q-valid edge, legal range 1..4
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   if_req/if_addr       fetch request, held until if_valid
//   if_valid/if_rdata    one-cycle fetch completion pulse and fetched word
//   dm_req/dm_we         data request (1 = store), held until dm_done
//   dm_addr/dm_wdata     data address and store data
//   dm_done/dm_rdata     one-cycle data completion pulse and load result
//   stall                combinational dm_req & ~dm_done
//   m_addr/m_data/m_rw   registered memory address, write data, write enable
//   m_q                  memory read data
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_rw,
  input  logic [DATA_W-1:0] m_q
);

  // Wait counter holds RD_LAT-1, at most 3
  localparam int unsigned CNT_W = 2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pri_q, pri_d;
  logic              owner_q, owner_d;

  logic              if_valid_d;
  logic [DATA_W-1:0] if_rdata_d;
  logic              dm_done_d;
  logic [DATA_W-1:0] dm_rdata_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [DATA_W-1:0] m_data_d;
  logic              m_rw_d;

  logic              if_elig;
  logic              dm_elig;
  logic              grant_dm;

  // Next-state, arbitration and registered-output next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pri_d      = pri_q;
    owner_d    = owner_q;
    if_valid_d = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata;
    dm_rdata_d = dm_rdata;
    m_addr_d   = m_addr;
    m_data_d   = m_data;
    m_rw_d     = 1'b0;

    // A port whose completion pulse is up this cycle is still holding its old
    // request; ignoring it here prevents serving the same request twice.
    if_elig  = if_req & ~if_valid;
    dm_elig  = dm_req & ~dm_done;
    grant_dm = dm_elig & (~if_elig | (pri_q == PORT_DM));

    case (state_q)
      IDLE: begin
        if (if_elig | dm_elig) begin
          owner_d  = grant_dm ? PORT_DM : PORT_IF;
          pri_d    = grant_dm ? PORT_IF : PORT_DM;
          m_addr_d = grant_dm ? dm_addr : if_addr;
          if (grant_dm && dm_we) begin
            m_rw_d   = 1'b1;
            m_data_d = dm_wdata;
            state_d  = WR;
          end else begin
            cnt_d   = CNT_W'(RD_LAT - 1);
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (owner_q == PORT_DM) begin
            dm_rdata_d = m_q;
            dm_done_d  = 1'b1;
          end else begin
            if_rdata_d = m_q;
            if_valid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      WR: begin
        // Write is committed at this edge; m_rw drops by default
        dm_done_d = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pri_q    <= PORT_DM;
      owner_q  <= PORT_IF;
      if_valid <= 1'b0;
      if_rdata <= '0;
      dm_done  <= 1'b0;
      dm_rdata <= '0;
      m_addr   <= '0;
      m_data   <= '0;
      m_rw     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pri_q    <= pri_d;
      owner_q  <= owner_d;
      if_valid <= if_valid_d;
      if_rdata <= if_rdata_d;
      dm_done  <= dm_done_d;
      dm_rdata <= dm_rdata_d;
      m_addr   <= m_addr_d;
      m_data   <= m_data_d;
      m_rw     <= m_rw_d;
    end
  end

  // Front of the pipeline freezes while a data access is outstanding
  assign stall = dm_req & ~dm_done;

endmodule
